vend_ctrl_change: RTL
=====================

Name: vend_ctrl_change

Overview:
Parametrised successor to the team's fixed-price 15-rupee vending controller. Accumulates credit in 5-rupee units up to a programmable price, then issues a one-cycle dispense pulse. Returns excess credit as a train of 5-rupee change pulses, supports cancel/refund, and tracks stock with sold-out lockout. Sits between the coin acceptor front-end and the dispense/change actuator drivers.

Parameters:
PRICE_UNITS, 3, item price in 5-rupee units (3 = 15 rupees); legal range 1..MAX_CREDIT_UNITS.
MAX_CREDIT_UNITS, 15, credit ceiling in units; must fit in CREDIT_W bits.
CREDIT_W, 4, width of the credit register.
STOCK_INIT, 8, stock count loaded at reset and on restock; must be at least 1.
STOCK_W, 4, width of the stock counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (asserted at 0).
coin  in  2  coin code: 00 none, 01 5 rupees (1 unit), 10 10 rupees (2 units), 11 20 rupees (4 units).
coin_valid  in  1  coin present this cycle; code 00 with valid is a no-op.
cancel  in  1  refund request, single-cycle pulse.
restock  in  1  reload stock to STOCK_INIT, single-cycle pulse.
dispense  out  1  one-cycle pulse, item released.
change_out  out  1  high one cycle per 5-rupee coin returned.
coin_reject  out  1  one-cycle pulse the cycle after a rejected coin.
busy  out  1  high in VEND and CHANGE.
sold_out  out  1  stock == 0.
credit  out  CREDIT_W  current credit in units.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, credit=0, stock=STOCK_INIT, outputs dispense/change_out/coin_reject/busy at 0, sold_out=0.
- States: IDLE (credit==0), ACCUM (0<credit<PRICE_UNITS), VEND, CHANGE. dispense, change_out and busy are Moore outputs decoded from the state register.
- Coin acceptance applies in IDLE/ACCUM only, when coin_valid=1 and coin!=00.
  - Reject if sold_out, or credit+units > MAX_CREDIT_UNITS, or cancel is high in the same cycle.
  - On reject: credit is unchanged and coin_reject=1 on the next cycle.
  - On accept: credit_next = credit+units. Compute the sum at CREDIT_W+1 bits so the overflow compare does not wrap.
- Transitions from IDLE/ACCUM:
  - Accepted coin with credit_next >= PRICE_UNITS -> VEND.
  - Otherwise -> ACCUM if credit_next > 0, else IDLE.
- VEND: lasts exactly one cycle.
  - dispense=1.
  - At the closing edge: credit -= PRICE_UNITS and stock -= 1.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE: change_out=1 each cycle and credit decrements by 1 per edge; -> IDLE on the edge where credit reaches 0. Remainder R produces exactly R consecutive change_out cycles.
- cancel in ACCUM -> CHANGE (refund the full credit). cancel in IDLE has no effect. cancel in VEND/CHANGE is ignored.
- Coins with coin_valid=1 during VEND/CHANGE are rejected (coin_reject the next cycle).
- restock: stock <= STOCK_INIT in any state except VEND, where it is ignored (the decrement wins). sold_out deasserts the cycle after restock.
- Latency: from the edge accepting the final coin, dispense is high in the next cycle and the first change_out in the cycle after that.
- rst asserted mid-VEND/CHANGE: immediate return to reset values; credit is lost and no further change is issued.
- stock never underflows: VEND is unreachable while sold_out because all coins are rejected.

Decomposition:
- Package vend_pkg holds:
  - coin code localparams (COIN_NONE, COIN_5, COIN_10, COIN_20);
  - the state enum (IDLE, ACCUM, VEND, CHANGE);
  - a function coin_units(code) returning 0/1/2/4.
- Single module with no sub-module. Credit arithmetic, the FSM and the stock counter are tightly coupled and small.

Test Plan:
- Reset, then coins 01,01,01 on consecutive cycles -> credit 1,2,3; dispense high one cycle; no change_out; return to IDLE with credit 0; stock 8->7.
- From IDLE, coin 11 (20 rupees) -> VEND (dispense), credit 4->1, then CHANGE with exactly 1 change_out pulse, then IDLE.
- Coin 10 then cancel -> CHANGE with 2 change_out pulses, no dispense, stock unchanged. Coin and cancel in the same cycle -> coin_reject next cycle, credit unchanged.
- MAX_CREDIT_UNITS=5, PRICE_UNITS=5, credit 2: coin 11 rejected (2+4>5) -> coin_reject pulse, credit stays 2; then coin 01 then coin 10 -> credit 5 -> dispense, no change.
- STOCK_INIT=1: one vend -> sold_out=1; coin 01 -> coin_reject, credit 0. restock -> sold_out=0 next cycle; coin 01 is then accepted.
- Drop rst low mid-CHANGE (credit 3) -> change_out, busy and credit go to 0 immediately and the FSM is in IDLE. Coin 01 during VEND -> coin_reject and credit unaffected.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: coin codes, controller states and coin value decoding for vend_ctrl_change
package vend_pkg;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_e;

    function automatic logic [2:0] coin_units(input logic [1:0] code);
        return code == COIN_5 ? 3'd1 : code == COIN_10 ? 3'd2 : code == COIN_20 ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/vend_ctrl_change.sv
// vend_ctrl_change: credit accumulation up to a programmable price, dispense pulse,
// 5-rupee change return, cancel refund and stock tracking with sold-out lockout
module vend_ctrl_change
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS      = 3,
    parameter int MAX_CREDIT_UNITS = 15,
    parameter int CREDIT_W         = 4,
    parameter int STOCK_INIT       = 8,
    parameter int STOCK_W          = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          coin_i,
    input  logic                coin_valid_i,
    input  logic                cancel_i,
    input  logic                restock_i,
    output logic                dispense_o,
    output logic                change_out_o,
    output logic                coin_reject_o,
    output logic                busy_o,
    output logic                sold_out_o,
    output logic [CREDIT_W-1:0] credit_o
);
    localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);
    localparam logic [CREDIT_W:0]   MAXC  = (CREDIT_W+1)'(MAX_CREDIT_UNITS);
    localparam logic [STOCK_W-1:0]  SINIT = STOCK_W'(STOCK_INIT);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                reject_q;
    logic                taking, coin_req, reject, accept;
    logic [CREDIT_W:0]   sum;

    // one extra bit keeps the ceiling compare from wrapping
    assign sum      = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units(coin_i));
    assign taking   = state_q == IDLE || state_q == ACCUM;
    assign coin_req = coin_valid_i && coin_i != COIN_NONE;
    assign reject   = coin_req && (!taking || sold_out_o || sum > MAXC || cancel_i);
    assign accept   = coin_req && !reject;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = sum >= {1'b0, PRICE} ? VEND : ACCUM;
                end else if (cancel_i && state_q == ACCUM) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE;
                stock_d  = stock_q - 1'b1;
                state_d  = credit_q > PRICE ? CHANGE : IDLE;
            end
            default: begin
                credit_d = credit_q - 1'b1;
                state_d  = credit_q == 1 ? IDLE : CHANGE;
            end
        endcase
        // the stock decrement in VEND takes priority over a restock
        if (restock_i && state_q != VEND) stock_d = SINIT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            credit_q <= '0;
            stock_q  <= SINIT;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
            reject_q <= reject;
        end
    end

    assign dispense_o    = state_q == VEND;
    assign change_out_o  = state_q == CHANGE;
    assign busy_o        = dispense_o || change_out_o;
    assign sold_out_o    = stock_q == '0;
    assign coin_reject_o = reject_q;
    assign credit_o      = credit_q;
endmodule
